// File: rtl/shift_sequencer.sv
// Multi-cycle controller for the external datapath shifter: steps the working
// value through the shifter one position per cycle and reports the final result.
module shift_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [CNT_W-1:0] amount,
  input  logic [WIDTH-1:0] operand,
  input  logic             carry_in,
  output logic [WIDTH-1:0] a_bus_out,
  output logic             a_bus_oe,
  output logic             sh_r,
  output logic             sh_l,
  output logic             sh_a,
  output logic             sh_b,
  output logic             sh_c,
  output logic             shs,
  input  logic [WIDTH-1:0] s_bus,
  input  logic             cf_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cf_out,
  output logic             op_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Shifter control lines for one op, packed as {Rin, Lin, Ain, Bin}.
  function automatic logic [3:0] decode_op(input logic [2:0] op_v);
    case (op_v)
      3'd0:    decode_op = 4'b0101;
      3'd1:    decode_op = 4'b1001;
      3'd2:    decode_op = 4'b1010;
      3'd3:    decode_op = 4'b0100;
      3'd4:    decode_op = 4'b1000;
      default: decode_op = 4'b0000;
    endcase
  endfunction

  state_t           state_r, state_nx_s;
  logic [WIDTH-1:0] work_r, work_nx_s;
  logic             carry_r, carry_nx_s;
  logic [CNT_W-1:0] cnt_r, cnt_nx_s;
  logic [2:0]       op_r, op_nx_s;
  logic             busy_r, busy_nx_s;
  logic             done_r, done_nx_s;
  logic [WIDTH-1:0] result_r, result_nx_s;
  logic             cf_out_r, cf_out_nx_s;
  logic             op_err_r, op_err_nx_s;
  logic             shift_r, shift_nx_s;
  logic [3:0]       sh_ctl_r, sh_ctl_nx_s;
  logic             illegal_s;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_nx_s  = state_r;
    work_nx_s   = work_r;
    carry_nx_s  = carry_r;
    cnt_nx_s    = cnt_r;
    op_nx_s     = op_r;
    busy_nx_s   = busy_r;
    done_nx_s   = 1'b0;
    result_nx_s = result_r;
    cf_out_nx_s = cf_out_r;
    op_err_nx_s = op_err_r;
    illegal_s   = (op > 3'd4);

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          work_nx_s   = operand;
          carry_nx_s  = carry_in;
          cnt_nx_s    = amount;
          op_nx_s     = op;
          busy_nx_s   = 1'b1;
          op_err_nx_s = 1'b0;
          // Nothing to shift: finish straight away with the operand untouched.
          if (illegal_s || (amount == {CNT_W{1'b0}})) begin
            state_nx_s  = ST_DONE;
            done_nx_s   = 1'b1;
            result_nx_s = operand;
            cf_out_nx_s = carry_in;
            op_err_nx_s = illegal_s;
          end else begin
            state_nx_s = ST_SHIFT;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        work_nx_s  = s_bus;
        carry_nx_s = cf_in;
        cnt_nx_s   = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_r == {{(CNT_W-1){1'b0}}, 1'b1}) begin
          state_nx_s  = ST_DONE;
          done_nx_s   = 1'b1;
          result_nx_s = s_bus;
          cf_out_nx_s = cf_in;
        end else begin
          state_nx_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_nx_s = ST_IDLE;
        busy_nx_s  = 1'b0;
      end
      default: begin
        state_nx_s = ST_IDLE;
        busy_nx_s  = 1'b0;
      end
    endcase

    shift_nx_s  = (state_nx_s == ST_SHIFT);
    sh_ctl_nx_s = shift_nx_s ? decode_op(op_nx_s) : 4'b0000;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      work_r   <= {WIDTH{1'b0}};
      carry_r  <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
      op_r     <= 3'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= {WIDTH{1'b0}};
      cf_out_r <= 1'b0;
      op_err_r <= 1'b0;
      shift_r  <= 1'b0;
      sh_ctl_r <= 4'b0000;
    end else begin
      state_r  <= state_nx_s;
      work_r   <= work_nx_s;
      carry_r  <= carry_nx_s;
      cnt_r    <= cnt_nx_s;
      op_r     <= op_nx_s;
      busy_r   <= busy_nx_s;
      done_r   <= done_nx_s;
      result_r <= result_nx_s;
      cf_out_r <= cf_out_nx_s;
      op_err_r <= op_err_nx_s;
      shift_r  <= shift_nx_s;
      sh_ctl_r <= sh_ctl_nx_s;
    end
  end

  assign a_bus_out = work_r;
  assign a_bus_oe  = shift_r;
  assign shs       = shift_r;
  assign sh_r      = sh_ctl_r[3];
  assign sh_l      = sh_ctl_r[2];
  assign sh_a      = sh_ctl_r[1];
  assign sh_b      = sh_ctl_r[0];
  assign sh_c      = carry_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign result    = result_r;
  assign cf_out    = cf_out_r;
  assign op_err    = op_err_r;

endmodule
